// File: rtl/gfx_mem_pkg.sv
// Shared constants for the frame-buffer BRAM port and its requesters.
package gfx_mem_pkg;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 32;
    localparam int NUM_REQ = 3;

    localparam logic [1:0] REQ_FETCH = 2'd0;
    localparam logic [1:0] REQ_RFILL = 2'd1;
    localparam logic [1:0] REQ_RPIX  = 2'd2;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/rd_return_pipe.sv
// (valid,id) delay line matching the registered-address plus BRAM read latency.
module rd_return_pipe
    import gfx_mem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic       in_valid,
    input  logic [1:0] in_id,
    output logic       bcast_xfc,
    output logic [1:0] bcast_id
);
    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [DEPTH-1:0][1:0] id_q, id_d;

    always_comb begin
        vld_d = {vld_q[DEPTH-2:0], in_valid};
        id_d  = {id_q[DEPTH-2:0], (in_valid ? in_id : REQ_FETCH)};
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            vld_q <= '0;
            id_q  <= '0;
        end else begin
            vld_q <= vld_d;
            id_q  <= id_d;
        end
    end

    assign bcast_xfc = vld_q[DEPTH-1];
    assign bcast_id  = id_q[DEPTH-1];
endmodule

// File: rtl/bram_port_scheduler.sv
// Arbitrates fetch and the two draw engines onto the single-port frame-buffer BRAM
// and broadcasts tagged read data after the fixed BRAM latency.
module bram_port_scheduler
    import gfx_mem_pkg::*;
#(
    parameter int RD_LAT    = 1,
    parameter int FETCH_MAX = 8
) (
    input  logic                             clk,
    input  logic                             rst_,
    input  logic                             enable,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_wrdata,
    input  logic [NUM_REQ-1:0]               req_op,
    input  logic [NUM_REQ-1:0]               req_rts,
    output logic [NUM_REQ-1:0]               req_rtr,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_data_out,
    output logic [3:0]                       wben,
    input  logic [DATA_W-1:0]                mem_data_in,
    output logic [DATA_W-1:0]                bcast_data,
    output logic                             bcast_xfc,
    output logic [1:0]                       bcast_id,
    output logic [2:0]                       sel
);
    localparam int FCNT_W = $clog2(FETCH_MAX + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FETCH_MAX);

    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [3:0]        wben_q, wben_d;

    logic [2:0]        grant;
    logic              draw_pend, guard, rd_valid;
    logic [1:0]        grant_id;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              grant_op;

    always_comb begin
        draw_pend = req_rts[REQ_RFILL] | req_rts[REQ_RPIX];
        guard     = draw_pend && (fcnt_q == FCNT_MAX);
        grant     = 3'b000;
        // rst_ gates grants so req_rtr/sel read as idle while reset is held.
        if (enable && rst_) begin
            if (req_rts[REQ_FETCH] && !guard)
                grant = 3'b001;
            else if (req_rts[REQ_RFILL] && req_rts[REQ_RPIX])
                grant = (rr_ptr_q == REQ_RPIX) ? 3'b100 : 3'b010;
            else if (req_rts[REQ_RFILL])
                grant = 3'b010;
            else if (req_rts[REQ_RPIX])
                grant = 3'b100;
        end

        grant_id   = REQ_FETCH;
        grant_addr = req_addr[REQ_FETCH];
        grant_data = req_wrdata[REQ_FETCH];
        grant_op   = req_op[REQ_FETCH];
        if (grant[REQ_RFILL]) begin
            grant_id   = REQ_RFILL;
            grant_addr = req_addr[REQ_RFILL];
            grant_data = req_wrdata[REQ_RFILL];
            grant_op   = req_op[REQ_RFILL];
        end else if (grant[REQ_RPIX]) begin
            grant_id   = REQ_RPIX;
            grant_addr = req_addr[REQ_RPIX];
            grant_data = req_wrdata[REQ_RPIX];
            grant_op   = req_op[REQ_RPIX];
        end

        fcnt_d = fcnt_q;
        if (grant[REQ_RFILL] || grant[REQ_RPIX] || !draw_pend)
            fcnt_d = '0;
        else if (grant[REQ_FETCH] && fcnt_q != FCNT_MAX)
            fcnt_d = fcnt_q + FCNT_W'(1);

        rr_ptr_d = rr_ptr_q;
        if (grant[REQ_RFILL])
            rr_ptr_d = REQ_RPIX;
        else if (grant[REQ_RPIX])
            rr_ptr_d = REQ_RFILL;

        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        wben_d     = 4'h0;
        if (|grant) begin
            mem_addr_d = grant_addr;
            mem_data_d = grant_data;
            wben_d     = (grant_op == OP_WR) ? 4'hF : 4'h0;
        end
        rd_valid = (|grant) && (grant_op == OP_RD);
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            fcnt_q     <= '0;
            rr_ptr_q   <= REQ_RFILL;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            wben_q     <= 4'h0;
        end else begin
            fcnt_q     <= fcnt_d;
            rr_ptr_q   <= rr_ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            wben_q     <= wben_d;
        end
    end

    rd_return_pipe #(.DEPTH(1 + RD_LAT)) u_rd_return_pipe (
        .clk       (clk),
        .rst_      (rst_),
        .in_valid  (rd_valid),
        .in_id     (grant_id),
        .bcast_xfc (bcast_xfc),
        .bcast_id  (bcast_id)
    );

    assign req_rtr      = grant;
    assign sel          = grant;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_data_q;
    assign wben         = wben_q;
    assign bcast_data   = mem_data_in;
endmodule

// File: tb/tb_bram_port_scheduler.sv
// Directed bench for bram_port_scheduler with a write-first BRAM model (RD_LAT=1, FETCH_MAX=8).
module tb_bram_port_scheduler;
    logic              clk = 1'b0;
    logic              rst_;
    logic              enable;
    logic [2:0][16:0]  req_addr;
    logic [2:0][31:0]  req_wrdata;
    logic [2:0]        req_op;
    logic [2:0]        req_rts;
    logic [2:0]        req_rtr;
    logic [16:0]       mem_addr;
    logic [31:0]       mem_data_out;
    logic [3:0]        wben;
    logic [31:0]       mem_data_in;
    logic [31:0]       bcast_data;
    logic              bcast_xfc;
    logic [1:0]        bcast_id;
    logic [2:0]        sel;

    int checks = 0;
    int errors = 0;

    bram_port_scheduler #(.RD_LAT(1), .FETCH_MAX(8)) dut (
        .clk          (clk),
        .rst_         (rst_),
        .enable       (enable),
        .req_addr     (req_addr),
        .req_wrdata   (req_wrdata),
        .req_op       (req_op),
        .req_rts      (req_rts),
        .req_rtr      (req_rtr),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .wben         (wben),
        .mem_data_in  (mem_data_in),
        .bcast_data   (bcast_data),
        .bcast_xfc    (bcast_xfc),
        .bcast_id     (bcast_id),
        .sel          (sel)
    );

    always #5 clk = ~clk;

    // Write-first BRAM: one edge from registered address to dout.
    logic [31:0] mem [0:131071];
    initial for (int i = 0; i < 131072; i++) mem[i] = 32'hA5A0_0000 + 32'(i);
    always @(posedge clk) begin
        if (wben == 4'hF) begin
            mem[mem_addr] <= mem_data_out;
            mem_data_in   <= mem_data_out;
        end else begin
            mem_data_in   <= mem[mem_addr];
        end
    end

    function automatic logic [31:0] fval(input int a);
        return 32'hA5A0_0000 + 32'(a);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        enable     = 1'b1;
        req_rts    = 3'b000;
        req_op     = 3'b000;
        req_addr   = '0;
        req_wrdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_ = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    typedef struct packed {
        logic       en;
        logic [2:0] rts;
        logic [2:0] exp_sel;
    } vec_t;

    vec_t vecs [13];

    initial begin
        // Sequential grant table from reset: rr_ptr starts at fill, fcnt at 0.
        vecs[0]  = '{1'b1, 3'b000, 3'b000};
        vecs[1]  = '{1'b1, 3'b001, 3'b001};
        vecs[2]  = '{1'b0, 3'b111, 3'b000};
        vecs[3]  = '{1'b1, 3'b110, 3'b010};
        vecs[4]  = '{1'b1, 3'b110, 3'b100};
        vecs[5]  = '{1'b1, 3'b100, 3'b100};
        vecs[6]  = '{1'b1, 3'b010, 3'b010};
        vecs[7]  = '{1'b1, 3'b010, 3'b010};
        vecs[8]  = '{1'b1, 3'b111, 3'b001};
        vecs[9]  = '{1'b1, 3'b101, 3'b001};
        vecs[10] = '{1'b1, 3'b001, 3'b001};
        vecs[11] = '{1'b1, 3'b111, 3'b001};
        vecs[12] = '{1'b1, 3'b110, 3'b100};

        rst_ = 1'b0;
        idle_inputs();
        req_rts = 3'b111;
        @(negedge clk);
        #1;
        chk("rst_rtr", 64'(req_rtr), 64'd0);
        chk("rst_sel", 64'(sel), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_data_out", 64'(mem_data_out), 64'd0);
        chk("rst_wben", 64'(wben), 64'd0);
        chk("rst_bcast_xfc", 64'(bcast_xfc), 64'd0);
        chk("rst_bcast_id", 64'(bcast_id), 64'd0);
        req_rts = 3'b000;
        @(negedge clk);
        rst_ = 1'b1;

        for (int v = 0; v < 13; v++) begin
            @(negedge clk);
            enable  = vecs[v].en;
            req_rts = vecs[v].rts;
            #1;
            chk($sformatf("table_sel[%0d]", v), 64'(sel), 64'(vecs[v].exp_sel));
            chk($sformatf("table_rtr[%0d]", v), 64'(req_rtr), 64'(vecs[v].exp_sel));
        end

        // Fetch-only back-to-back reads at 0x10..0x13.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c < 4) begin
                req_rts     = 3'b001;
                req_addr[0] = 17'(16 + c);
                req_op[0]   = 1'b0;
            end else begin
                req_rts = 3'b000;
            end
            #1;
            chk($sformatf("t1_rtr[%0d]", c), 64'(req_rtr), (c < 4) ? 64'd1 : 64'd0);
            if (c >= 1)
                chk($sformatf("t1_mem_addr[%0d]", c), 64'(mem_addr), 64'(16 + ((c <= 4) ? c - 1 : 3)));
            chk($sformatf("t1_wben[%0d]", c), 64'(wben), 64'd0);
            chk($sformatf("t1_bcast_xfc[%0d]", c), 64'(bcast_xfc), (c >= 2 && c <= 5) ? 64'd1 : 64'd0);
            if (c >= 2 && c <= 5) begin
                chk($sformatf("t1_bcast_id[%0d]", c), 64'(bcast_id), 64'd0);
                chk($sformatf("t1_bcast_data[%0d]", c), 64'(bcast_data), 64'(fval(16 + c - 2)));
            end
        end

        // Fill and pix contending, fetch idle: strict alternation.
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_rts = 3'b110;
            #1;
            chk($sformatf("t2_sel[%0d]", c), 64'(sel), (c % 2 == 0) ? 64'b010 : 64'b100);
        end

        // All three held: 8 fetch grants then one draw grant, draw alternating.
        do_reset();
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            req_rts = 3'b111;
            #1;
            chk($sformatf("t3_sel[%0d]", c), 64'(sel),
                (c % 9 < 8) ? 64'b001 : ((c / 9 == 0) ? 64'b010 : 64'b100));
        end

        // Pix write then fetch read of the same word: write-first return.
        do_reset();
        @(negedge clk);
        req_rts       = 3'b100;
        req_addr[2]   = 17'h1ABCD;
        req_wrdata[2] = 32'hDEADBEEF;
        req_op[2]     = 1'b1;
        #1;
        chk("t4_sel_wr", 64'(sel), 64'b100);
        @(negedge clk);
        req_rts     = 3'b001;
        req_addr[0] = 17'h1ABCD;
        req_op[0]   = 1'b0;
        #1;
        chk("t4_sel_rd", 64'(sel), 64'b001);
        chk("t4_wben_wr", 64'(wben), 64'hF);
        chk("t4_mem_addr", 64'(mem_addr), 64'h1ABCD);
        chk("t4_mem_data_out", 64'(mem_data_out), 64'hDEADBEEF);
        chk("t4_no_bcast_c1", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
        req_rts = 3'b000;
        #1;
        chk("t4_wben_rd", 64'(wben), 64'h0);
        chk("t4_no_bcast_c2", 64'(bcast_xfc), 64'd0);
        @(negedge clk);
        #1;
        chk("t4_bcast_xfc", 64'(bcast_xfc), 64'd1);
        chk("t4_bcast_id", 64'(bcast_id), 64'd0);
        chk("t4_bcast_data", 64'(bcast_data), 64'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("t4_bcast_end", 64'(bcast_xfc), 64'd0);

        // enable drops with two reads in flight.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c < 2) begin
                req_rts     = 3'b001;
                req_addr[0] = 17'(32 + c);
                req_op[0]   = 1'b0;
            end else begin
                enable  = 1'b0;
                req_rts = 3'b111;
            end
            #1;
            if (c >= 2) begin
                chk($sformatf("t5_rtr[%0d]", c), 64'(req_rtr), 64'd0);
                chk($sformatf("t5_sel[%0d]", c), 64'(sel), 64'd0);
            end
            chk($sformatf("t5_bcast_xfc[%0d]", c), 64'(bcast_xfc), (c == 2 || c == 3) ? 64'd1 : 64'd0);
            if (c == 2 || c == 3) begin
                chk($sformatf("t5_bcast_id[%0d]", c), 64'(bcast_id), 64'd0);
                chk($sformatf("t5_bcast_data[%0d]", c), 64'(bcast_data), 64'(fval(32 + c - 2)));
            end
        end

        // Reset pulse with two fill reads in flight.
        do_reset();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            req_rts     = 3'b010;
            req_addr[1] = 17'(48 + c);
            req_op[1]   = 1'b0;
            #1;
            chk($sformatf("t6_sel[%0d]", c), 64'(sel), 64'b010);
        end
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        chk("t6_rtr", 64'(req_rtr), 64'd0);
        chk("t6_sel", 64'(sel), 64'd0);
        chk("t6_mem_addr", 64'(mem_addr), 64'd0);
        chk("t6_wben", 64'(wben), 64'd0);
        chk("t6_bcast_xfc", 64'(bcast_xfc), 64'd0);
        chk("t6_bcast_id", 64'(bcast_id), 64'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rst_    = 1'b1;
            req_rts = 3'b000;
            #1;
            chk($sformatf("t6_no_bcast[%0d]", c), 64'(bcast_xfc), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
